// File: rtl/fpu_pkg.sv
// fpu_pkg: shared states, widths and memory-request record for the FPU request path.
package fpu_pkg;
  localparam int FPU_LINE_BYTES = 64;
  localparam int FPU_DIM_W = 17;
  localparam int FPU_STRIDE_W = 19;
  localparam int FPU_ADDR_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} fpu_req_state_t;
  typedef struct packed {
    logic                  write;
    logic [FPU_ADDR_W-1:0] addr;
    logic [6:0]            len;
  } fpu_mem_req_t;
endpackage

// File: rtl/fpu_req_addr_gen.sv
// fpu_req_addr_gen: row/column walk producing line-sized request address and length.
module fpu_req_addr_gen
  import fpu_pkg::*;
#(
  parameter int LINE_BYTES = FPU_LINE_BYTES,
  parameter int ADDR_W = FPU_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    step,
  input  logic [ADDR_W-1:0]       base,
  input  logic [FPU_STRIDE_W-1:0] stride_in,
  input  logic [FPU_DIM_W-1:0]    width,
  input  logic [FPU_DIM_W-1:0]    height,
  output logic [ADDR_W-1:0]       addr,
  output logic [6:0]              len,
  output logic                    last
);
  logic [ADDR_W-1:0] row_base, stride;
  logic [FPU_DIM_W-1:0] col_off, row, rem;
  logic row_end;
  always_comb begin
    rem = width - col_off;
    row_end = rem <= FPU_DIM_W'(LINE_BYTES);
    len = row_end ? rem[6:0] : 7'(LINE_BYTES);
    addr = row_base + ADDR_W'(col_off);
    last = row_end && (row + FPU_DIM_W'(1) == height);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      stride <= '0;
      col_off <= '0;
      row <= '0;
    end else if (load) begin
      row_base <= base;
      stride <= ADDR_W'(stride_in);
      col_off <= '0;
      row <= '0;
    end else if (step) begin
      col_off <= row_end ? '0 : col_off + FPU_DIM_W'(len);
      row_base <= row_end ? row_base + stride : row_base;
      row <= row_end ? row + FPU_DIM_W'(1) : row;
    end
  end
endmodule

// File: rtl/fpu_req_ctrl.sv
// fpu_req_ctrl: turns FPU read/write jobs into line-sized memory requests.
// Optional stall counter on perf_stall_cycles enabled by FPU_REQ_PERF_EN.
module fpu_req_ctrl
  import fpu_pkg::*;
#(
  parameter int LINE_BYTES = FPU_LINE_BYTES,
  parameter int ADDR_W = FPU_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [FPU_DIM_W-1:0]    width,
  input  logic [FPU_DIM_W-1:0]    height,
  input  logic [ADDR_W-1:0]       read_address,
  input  logic [ADDR_W-1:0]       write_address,
  input  logic [FPU_STRIDE_W-1:0] input_row_width,
  input  logic [FPU_STRIDE_W-1:0] output_row_width,
  output logic                    making_request,
  output logic                    job_done,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [6:0]              mem_req_len,
  output logic [31:0]             perf_stall_cycles
);
  fpu_req_state_t state, nxt;
  logic pend_wr, job_wr, start, load, step, last;
  logic [ADDR_W-1:0] wr_base, ld_base, ag_addr;
  logic [FPU_STRIDE_W-1:0] wr_stride, ld_stride;
  logic [FPU_DIM_W-1:0] width_r, height_r;
  logic [6:0] ag_len;
  fpu_mem_req_t req;
  assign start = (state == IDLE) && (read || write);
  assign step = (state == ISSUE) && mem_req_ready;
  always_comb begin
    nxt = state;
    load = 1'b0;
    ld_base = read ? read_address : write_address;
    ld_stride = read ? input_row_width : output_row_width;
    unique case (state)
      IDLE: if (read || write) begin
        load = 1'b1;
        nxt = (width == '0 || height == '0) ? FINISH : ISSUE;
      end
      ISSUE: nxt = (step && last) ? FINISH : ISSUE;
      FINISH: begin
        load = pend_wr;
        ld_base = wr_base;
        ld_stride = wr_stride;
        // a queued write of zero size just takes one more FINISH cycle
        nxt = !pend_wr ? IDLE : (width_r == '0 || height_r == '0) ? FINISH : ISSUE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend_wr <= 1'b0;
      job_wr <= 1'b0;
      wr_base <= '0;
      wr_stride <= '0;
      width_r <= '0;
      height_r <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        pend_wr <= read && write;
        job_wr <= !read;
        wr_base <= write_address;
        wr_stride <= output_row_width;
        width_r <= width;
        height_r <= height;
      end else if (state == FINISH && pend_wr) begin
        pend_wr <= 1'b0;
        job_wr <= 1'b1;
      end
    end
  end
  fpu_req_addr_gen #(.LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .step(step),
    .base(ld_base),
    .stride_in(ld_stride),
    .width(width_r),
    .height(height_r),
    .addr(ag_addr),
    .len(ag_len),
    .last(last)
  );
  always_comb begin
    req.write = (state == ISSUE) && job_wr;
    req.addr = (state == ISSUE) ? FPU_ADDR_W'(ag_addr) : '0;
    req.len = (state == ISSUE) ? ag_len : '0;
  end
  assign making_request = state != IDLE;
  assign job_done = state == FINISH;
  assign mem_req_valid = state == ISSUE;
  assign mem_req_write = req.write;
  assign mem_req_addr = ADDR_W'(req.addr);
  assign mem_req_len = req.len;
`ifdef FPU_REQ_PERF_EN
  logic [31:0] stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall <= '0;
    else if (start) stall <= '0;
    else if (mem_req_valid && !mem_req_ready && stall != '1) stall <= stall + 32'd1;
  end
  assign perf_stall_cycles = stall;
`else
  assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fpu_req_ctrl.sv
// tb_fpu_req_ctrl: job-level request model compared every cycle, plus directed literal checks.
module tb_fpu_req_ctrl;
  typedef struct packed {logic w; logic [31:0] a; logic [6:0] l;} req_t;
  logic clk = 0, rst_n = 0, read = 0, write = 0, ready = 1;
  logic [16:0] width = 0, height = 0;
  logic [31:0] ra = 0, wa = 0;
  logic [18:0] irw = 0, orw = 0;
  logic making, done, valid, req_wr;
  logic [31:0] addr, perf;
  logic [6:0] len;
  int pass = 0, tot = 0;
  int mk_cnt = 0, done_cnt = 0, vld_cnt = 0, mk_fall = 0;
  int mk0, d0, v0, f0, l0;
  logic prev_mk = 0;
  req_t exp_q[$], log_q[$];

  fpu_req_ctrl dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .width(width), .height(height),
    .read_address(ra), .write_address(wa), .input_row_width(irw), .output_row_width(orw),
    .making_request(making), .job_done(done), .mem_req_valid(valid), .mem_req_ready(ready),
    .mem_req_write(req_wr), .mem_req_addr(addr), .mem_req_len(len), .perf_stall_cycles(perf)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s actual=%0h required=%0h", n, act, exp);
  endtask

  function automatic void push_job(bit w, logic [31:0] base, logic [18:0] stride, int wd, int ht);
    for (int r = 0; r < ht; r++)
      for (int c = 0; c < wd; c += 64)
        exp_q.push_back('{w, base + 32'(r) * {13'b0, stride} + 32'(c), 7'((wd - c > 64) ? 64 : wd - c)});
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_mk <= 0;
    end else begin
      if (making) mk_cnt++;
      if (done) done_cnt++;
      if (prev_mk && !making) mk_fall++;
      prev_mk <= making;
      if (valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          tot++;
          $display("FAIL req_unexpected actual=%0h/%0d required=none", addr, len);
        end else begin
          chk("req", {24'b0, req_wr, addr, len}, {24'b0, exp_q[0]});
          if (ready) begin
            log_q.push_back('{req_wr, addr, len});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic snap();
    mk0 = mk_cnt; d0 = done_cnt; v0 = vld_cnt; f0 = mk_fall; l0 = log_q.size();
  endtask

  task automatic start_job(bit rd, bit wr, int w, int h, logic [31:0] r_a, logic [31:0] w_a,
                           logic [18:0] r_s, logic [18:0] w_s);
    snap();
    read = rd; write = wr; width = 17'(w); height = 17'(h);
    ra = r_a; wa = w_a; irw = r_s; orw = w_s;
    if (rd) push_job(0, r_a, r_s, w, h);
    if (wr) push_job(1, w_a, w_s, w, h);
    @(posedge clk); #1;
    read = 0; write = 0;
    width = 17'h1abcd; height = 17'h00777; ra = 32'hdeadbeef; wa = 32'hcafef00d; irw = 19'h7; orw = 19'h3;
  endtask

  task automatic wait_job(int limit);
    int n = 0;
    while ((making || exp_q.size() != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    tot++;
    if (n < limit) pass++;
    else $display("FAIL job_timeout actual=%0d required<%0d", n, limit);
    chk("all_issued", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_making", making, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_len", {addr, len}, 0);
    chk("rst_perf", perf, 0);
    rst_n = 1;
    @(posedge clk); #1;

    start_job(1, 0, 64, 3, 32'h1000, 0, 19'h100, 0);
    chk("model_pin", exp_q[2].a, 32'h1200);
    wait_job(50);
    chk("t1_mk", mk_cnt - mk0, 4);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_req2", log_q[l0+2], {1'b0, 32'h1200, 7'd64});

    start_job(1, 0, 150, 2, 32'h2000, 0, 19'h200, 0);
    wait_job(50);
    chk("t2_count", log_q.size() - l0, 6);
    chk("t2_req2", log_q[l0+2], {1'b0, 32'h2080, 7'd22});
    chk("t2_req4", log_q[l0+4], {1'b0, 32'h2240, 7'd64});
    chk("t2_req5", log_q[l0+5], {1'b0, 32'h2280, 7'd22});

    start_job(1, 1, 64, 1, 32'h3000, 32'h8000, 19'h40, 19'h40);
    wait_job(50);
    chk("t3_done", done_cnt - d0, 2);
    chk("t3_mk", mk_cnt - mk0, 4);
    chk("t3_fall", mk_fall - f0, 1);
    chk("t3_rd", log_q[l0], {1'b0, 32'h3000, 7'd64});
    chk("t3_wr", log_q[l0+1], {1'b1, 32'h8000, 7'd64});

    ready = 0;
    start_job(1, 0, 64, 1, 32'h4000, 0, 19'h40, 0);
    repeat (5) @(posedge clk);
    #1 ready = 1;
    wait_job(50);
    chk("t4_vld", vld_cnt - v0, 6);
`ifdef FPU_REQ_PERF_EN
    chk("t4_perf", perf, 5);
`else
    chk("t4_perf", perf, 0);
`endif

    start_job(1, 0, 64, 0, 32'h5000, 0, 19'h40, 0);
    wait_job(20);
    chk("t5_vld", vld_cnt - v0, 0);
    chk("t5_mk", mk_cnt - mk0, 1);
    chk("t5_done", done_cnt - d0, 1);

    start_job(1, 0, 64, 2, 32'hffffffc0, 0, 19'h80, 0);
    wait_job(20);
    chk("t6_wrap", log_q[l0+1], {1'b0, 32'h00000040, 7'd64});

    start_job(1, 0, 64, 3, 32'h6000, 0, 19'h100, 0);
    @(posedge clk); #1;
    chk("t7_pre", {valid, addr}, {1'b1, 32'h6100});
    rst_n = 0;
    #1;
    chk("t7_making", making, 0);
    chk("t7_valid", valid, 0);
    chk("t7_done", done, 0);
    chk("t7_addr_len", {addr, len}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    snap();
    repeat (6) @(posedge clk);
    #1;
    chk("t7_no_req", vld_cnt - v0, 0);
    chk("t7_idle", mk_cnt - mk0, 0);

    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
